// File: rtl/stdcell_exerciser_if.sv
// Control, status and cell-array bus of the standard-cell exerciser.
// master: Caravel control logic plus the cell array; slave: the exerciser.
interface stdcell_exerciser_if #(
  parameter int NCELLS = 8,
  parameter int NIN    = 4
);
  logic              start;
  logic              abort;
  logic [1:0]        mode;
  logic [15:0]       num_vec;
  logic [3:0]        settle;
  logic [NIN-1:0]    static_vec;
  logic [NIN-1:0]    cell_in;
  logic [NCELLS-1:0] cell_out;
  logic [NCELLS-1:0] exp_out;
  logic              busy;
  logic              done;
  logic [NCELLS-1:0] fail_mask;
  logic [15:0]       err_count;
  logic              first_fail_valid;
  logic [NIN-1:0]    first_fail_vec;

  modport master (
    output start, abort, mode, num_vec, settle, static_vec, cell_out, exp_out,
    input  cell_in, busy, done, fail_mask, err_count, first_fail_valid, first_fail_vec
  );

  modport slave (
    input  start, abort, mode, num_vec, settle, static_vec, cell_out, exp_out,
    output cell_in, busy, done, fail_mask, err_count, first_fail_valid, first_fail_vec
  );
endinterface

// File: rtl/stdcell_exerciser.sv
// On-wafer standard-cell exerciser: drives a shared stimulus vector into the
// cell array, waits a programmable settle time, compares the cell outputs with
// golden values and accumulates sticky failure flags, a saturating error count
// and the first failing vector.
module stdcell_exerciser #(
  parameter int NCELLS = 8,
  parameter int NIN    = 4
) (
  input logic               clk,
  input logic               rst_n,
  stdcell_exerciser_if.slave bus
);

  typedef enum logic [2:0] {IDLE, APPLY, SETTLE, SAMPLE, DONE} state_t;

  localparam logic [1:0]  MODE_EX   = 2'b00;
  localparam logic [1:0]  MODE_RND  = 2'b01;
  localparam logic [1:0]  MODE_HOLD = 2'b10;
  localparam logic [15:0] SEED      = 16'hACE1;
  localparam logic [15:0] POLY      = 16'hB400;
  localparam logic [16:0] LAST_EX   = (17'd1 << NIN) - 17'd1;

  state_t            state;
  logic [1:0]        mode_q;
  logic [15:0]       num_q;
  logic [3:0]        settle_q;
  logic [3:0]        cnt;
  logic [15:0]       lfsr;
  logic [15:0]       idx;
  logic [NIN-1:0]    cell_in_q;
  logic              busy_q;
  logic              done_q;
  logic [NCELLS-1:0] fail_q;
  logic [15:0]       err_q;
  logic              ffv_q;
  logic [NIN-1:0]    ffvec_q;

  logic [1:0]        mode_eff;
  logic [NCELLS-1:0] mm;
  logic [15:0]       lfsr_nx;
  logic [15:0]       idx_nx;
  logic              last_vec;

  // Galois LFSR, right shift, taps 16'hB400.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return (l >> 1) ^ (l[0] ? POLY : 16'h0000);
  endfunction

  // Error counter increment that sticks at all-ones.
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Stimulus selection for the next APPLY cycle.
  function automatic logic [NIN-1:0] vec_sel(input logic [1:0]     m,
                                             input logic [NIN-1:0] iv,
                                             input logic [NIN-1:0] lv,
                                             input logic [NIN-1:0] sv);
    case (m)
      MODE_RND:  return lv;
      MODE_HOLD: return sv;
      default:   return iv;
    endcase
  endfunction

  // Mode decode, mismatch vector, next index/LFSR and end-of-run detection.
  always_comb begin
    mode_eff = (bus.mode == 2'b11) ? MODE_EX : bus.mode;
    mm       = bus.cell_out ^ bus.exp_out;
    lfsr_nx  = lfsr_step(lfsr);
    idx_nx   = idx + 16'd1;
    case (mode_q)
      MODE_EX:  last_vec = ({1'b0, idx} == LAST_EX);
      MODE_RND: last_vec = (({1'b0, idx} + 17'd1) == {1'b0, num_q});
      default:  last_vec = 1'b0;
    endcase
  end

  // Run sequencer with registered stimulus, status and result outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      mode_q    <= MODE_EX;
      num_q     <= 16'd0;
      settle_q  <= 4'd0;
      cnt       <= 4'd0;
      lfsr      <= SEED;
      idx       <= 16'd0;
      cell_in_q <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      fail_q    <= '0;
      err_q     <= 16'd0;
      ffv_q     <= 1'b0;
      ffvec_q   <= '0;
    end else begin
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            mode_q   <= mode_eff;
            num_q    <= bus.num_vec;
            settle_q <= bus.settle;
            fail_q   <= '0;
            err_q    <= 16'd0;
            ffv_q    <= 1'b0;
            ffvec_q  <= '0;
            lfsr     <= SEED;
            idx      <= 16'd0;
            if (mode_eff == MODE_RND && bus.num_vec == 16'd0) begin
              state  <= DONE;
              done_q <= 1'b1;
            end else begin
              state     <= APPLY;
              busy_q    <= 1'b1;
              cell_in_q <= vec_sel(mode_eff, '0, SEED[NIN-1:0], bus.static_vec);
            end
          end
        end
        APPLY: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (settle_q != 4'd0) begin
            state <= SETTLE;
            cnt   <= settle_q;
          end else begin
            state <= SAMPLE;
          end
        end
        SETTLE: begin
          if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (cnt == 4'd1) begin
            state <= SAMPLE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        SAMPLE: begin
          fail_q <= fail_q | mm;
          if (mm != '0) begin
            err_q <= sat_inc(err_q);
            if (!ffv_q) begin
              ffv_q   <= 1'b1;
              ffvec_q <= cell_in_q;
            end
          end
          idx  <= idx_nx;
          lfsr <= lfsr_nx;
          if (bus.abort) begin
            state  <= IDLE;
            busy_q <= 1'b0;
          end else if (last_vec) begin
            state  <= DONE;
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end else begin
            state     <= APPLY;
            cell_in_q <= vec_sel(mode_q, idx_nx[NIN-1:0], lfsr_nx[NIN-1:0], bus.static_vec);
          end
        end
        DONE:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.cell_in          = cell_in_q;
  assign bus.busy             = busy_q;
  assign bus.done             = done_q;
  assign bus.fail_mask        = fail_q;
  assign bus.err_count        = err_q;
  assign bus.first_fail_valid = ffv_q;
  assign bus.first_fail_vec   = ffvec_q;

endmodule

// File: tb/tb_stdcell_exerciser.sv
// Directed testbench for stdcell_exerciser: a NIN=4 instance covers fault
// injection, random/hold modes, abort and reset; a NIN=2 instance covers the
// clean exhaustive pass with a NAND cell model.
module tb_stdcell_exerciser;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  stdcell_exerciser_if #(.NCELLS(8), .NIN(4)) ifa ();
  stdcell_exerciser_if #(.NCELLS(8), .NIN(2)) ifb ();

  stdcell_exerciser #(.NCELLS(8), .NIN(4)) dut_a (.clk(clk), .rst_n(rst_n), .bus(ifa));
  stdcell_exerciser #(.NCELLS(8), .NIN(2)) dut_b (.clk(clk), .rst_n(rst_n), .bus(ifb));

  int checks = 0;
  int errors = 0;
  int scen   = 0;
  int done_k;
  int kk;
  logic busy_seen;
  logic done_seen;
  logic [3:0] rnd_exp [5] = '{4'h1, 4'h0, 4'h8, 4'hC, 4'hE};
  logic [7:0] and2_a;

  // Cell array models for instance A, selected per scenario.
  assign and2_a = {8{ifa.cell_in[0] & ifa.cell_in[1]}};
  always_comb begin
    ifa.exp_out  = 8'h00;
    ifa.cell_out = 8'h00;
    case (scen)
      1: begin ifa.exp_out = and2_a; ifa.cell_out = and2_a | 8'h08; end
      2: ifa.cell_out = (ifa.cell_in == 4'h8) ? 8'h02 : 8'h00;
      3: ifa.cell_out = 8'h01;
      default: ;
    endcase
  end

  // Instance B: every cell is a correct NAND2 of the stimulus.
  assign ifb.exp_out  = {8{~&ifb.cell_in}};
  assign ifb.cell_out = {8{~&ifb.cell_in}};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic start_a(input logic [1:0] m, input logic [15:0] n,
                         input logic [3:0] s, input logic [3:0] sv);
    @(negedge clk);
    ifa.mode = m; ifa.num_vec = n; ifa.settle = s; ifa.static_vec = sv;
    ifa.start = 1'b1;
    @(posedge clk); #1;
    ifa.start = 1'b0;
  endtask

  task automatic wait_done_a(input int maxc, output int k);
    k = 1;
    while (!ifa.done && k < maxc) begin
      @(posedge clk); #1;
      k++;
    end
  endtask

  initial begin
    ifa.start = 0; ifa.abort = 0; ifa.mode = 0; ifa.num_vec = 0; ifa.settle = 0; ifa.static_vec = 0;
    ifb.start = 0; ifb.abort = 0; ifb.mode = 0; ifb.num_vec = 0; ifb.settle = 0; ifb.static_vec = 0;
    rst_n = 1'b0;
    #1;
    chk("rst_cell_in", ifa.cell_in, 0);
    chk("rst_busy", ifa.busy, 0);
    chk("rst_done", ifa.done, 0);
    chk("rst_fail_mask", ifa.fail_mask, 0);
    chk("rst_err_count", ifa.err_count, 0);
    chk("rst_ffv", ifa.first_fail_valid, 0);
    chk("rst_ffvec", ifa.first_fail_vec, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Clean exhaustive pass, NIN=2, settle 0.
    @(negedge clk);
    ifb.mode = 2'b00; ifb.settle = 4'd0; ifb.start = 1'b1;
    @(posedge clk); #1;
    ifb.start = 1'b0;
    done_k = 0;
    for (int k = 1; k <= 12; k++) begin
      if (k == 1 || k == 3 || k == 5 || k == 7) chk("clean_cell_in", ifb.cell_in, (k - 1) / 2);
      if (k == 8) chk("clean_busy_t8", ifb.busy, 1);
      if (k == 9) chk("clean_busy_t9", ifb.busy, 0);
      if (ifb.done && done_k == 0) done_k = k;
      @(posedge clk); #1;
    end
    chk("clean_done_cyc", done_k, 9);
    chk("clean_fail_mask", ifb.fail_mask, 0);
    chk("clean_err_count", ifb.err_count, 0);
    chk("clean_ffv", ifb.first_fail_valid, 0);

    // Injected fault: cell 3 stuck-at-1 against AND2 golden, NIN=4.
    scen = 1;
    start_a(2'b00, 16'd0, 4'd0, 4'h0);
    wait_done_a(100, kk);
    chk("fault_done_cyc", kk, 33);
    chk("fault_fail_mask", ifa.fail_mask, 8'h08);
    chk("fault_err_count", ifa.err_count, 12);
    chk("fault_ffv", ifa.first_fail_valid, 1);
    chk("fault_ffvec", ifa.first_fail_vec, 0);
    repeat (2) @(posedge clk); #1;

    // Random, num_vec 5, settle 3; cell 1 fails only on vector 8.
    scen = 2;
    start_a(2'b01, 16'd5, 4'd3, 4'h0);
    done_k = 0;
    for (int k = 1; k <= 30; k++) begin
      if ((k % 5) == 1 && k <= 21) chk("rnd_cell_in", ifa.cell_in, rnd_exp[(k - 1) / 5]);
      if (ifa.done && done_k == 0) done_k = k;
      @(posedge clk); #1;
    end
    chk("rnd_done_cyc", done_k, 26);
    chk("rnd_err_count", ifa.err_count, 1);
    chk("rnd_fail_mask", ifa.fail_mask, 8'h02);
    chk("rnd_ffv", ifa.first_fail_valid, 1);
    chk("rnd_ffvec", ifa.first_fail_vec, 4'h8);

    // Random with zero count completes at once and clears results.
    scen = 0;
    start_a(2'b01, 16'd0, 4'd0, 4'h0);
    done_k = 0; busy_seen = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      if (ifa.busy) busy_seen = 1'b1;
      if (ifa.done && done_k == 0) done_k = k;
      @(posedge clk); #1;
    end
    chk("zero_done_cyc", done_k, 1);
    chk("zero_busy_seen", busy_seen, 0);
    chk("zero_fail_mask", ifa.fail_mask, 0);
    chk("zero_err_count", ifa.err_count, 0);
    chk("zero_ffv", ifa.first_fail_valid, 0);

    // Hold 4'hA with cell 0 failing, abort on the 10th SAMPLE.
    scen = 3;
    start_a(2'b10, 16'd0, 4'd0, 4'hA);
    done_seen = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      if (k == 1) chk("hold_cell_in", ifa.cell_in, 4'hA);
      if (ifa.done) done_seen = 1'b1;
      if (k == 20) ifa.abort = 1'b1;
      @(posedge clk); #1;
    end
    ifa.abort = 1'b0;
    if (ifa.done) done_seen = 1'b1;
    chk("abort_busy", ifa.busy, 0);
    chk("abort_err_count", ifa.err_count, 10);
    chk("abort_fail_mask", ifa.fail_mask, 8'h01);
    chk("abort_ffv", ifa.first_fail_valid, 1);
    chk("abort_ffvec", ifa.first_fail_vec, 4'hA);
    repeat (5) begin
      @(posedge clk); #1;
      if (ifa.done) done_seen = 1'b1;
    end
    chk("abort_no_done", done_seen, 0);
    chk("abort_persist_err", ifa.err_count, 10);
    scen = 0;
    start_a(2'b00, 16'd0, 4'd0, 4'h0);
    chk("restart_err_cleared", ifa.err_count, 0);
    chk("restart_fail_cleared", ifa.fail_mask, 0);
    chk("restart_ffv_cleared", ifa.first_fail_valid, 0);
    wait_done_a(100, kk);
    chk("restart_done_cyc", kk, 33);
    repeat (2) @(posedge clk); #1;

    // Reset mid-run during SETTLE, after a start issued while busy.
    scen = 3;
    start_a(2'b01, 16'd3, 4'd5, 4'h0);
    for (int k = 1; k <= 9; k++) begin
      if (k == 2) ifa.start = 1'b1;
      if (k == 3) ifa.start = 1'b0;
      if (k == 8) begin
        chk("busy_start_ignored", ifa.cell_in, 4'h0);
        chk("midrun_err_count", ifa.err_count, 1);
      end
      if (k < 9) begin @(posedge clk); #1; end
    end
    #2 rst_n = 1'b0;
    #1;
    chk("arst_cell_in", ifa.cell_in, 0);
    chk("arst_busy", ifa.busy, 0);
    chk("arst_fail_mask", ifa.fail_mask, 0);
    chk("arst_err_count", ifa.err_count, 0);
    chk("arst_ffv", ifa.first_fail_valid, 0);
    chk("arst_ffvec", ifa.first_fail_vec, 0);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) @(posedge clk); #1;
    chk("post_rst_idle_busy", ifa.busy, 0);
    chk("post_rst_idle_done", ifa.done, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
